// File: rtl/sram_burst_pkg.sv
// rtl/sram_burst_pkg.sv - command encodings and FSM state type for the SRAM burst controller
package sram_burst_pkg;

  localparam logic [1:0] CMD_LOAD_LO = 2'd0;
  localparam logic [1:0] CMD_LOAD_HI = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;
  localparam logic [1:0] CMD_READ    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_CAP   = 2'd3
  } state_t;

  // Lane-index width for a RAM word of wb bytes (1, 2 or 4).
  function automatic int lane_bits(input int wb);
    return (wb == 4) ? 2 : ((wb == 2) ? 1 : 0);
  endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// rtl/sram_burst_ctrl_if.sv - single-port SRAM macro bus (controller = master, RAM = slave)
interface sram_burst_ctrl_if #(
  parameter int WORD_BYTES = 4,
  parameter int RAM_AW     = 9
);

  logic                    ram_csb0;
  logic                    ram_web0;
  logic [WORD_BYTES-1:0]   ram_wmask0;
  logic [RAM_AW-1:0]       ram_addr0;
  logic [8*WORD_BYTES-1:0] ram_din0;
  logic [8*WORD_BYTES-1:0] ram_dout0;

  modport master (
    output ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0,
    input  ram_dout0
  );

  modport slave (
    input  ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0,
    output ram_dout0
  );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer for the host strobe with rising-edge detect
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // One pulse per low-to-high transition, however long the strobe stays high.
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - byte-wide host port to a word-wide single-port SRAM with
// auto-incrementing address, single-byte write and read-capture.
module sram_burst_ctrl
  import sram_burst_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int WORD_BYTES = 4,
  parameter int RAM_AW     = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uo_out,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic        ram_clk0,
  sram_burst_ctrl_if.master ram
);

  localparam int LB = lane_bits(WORD_BYTES);
  localparam int LW = (LB == 0) ? 1 : LB;
  localparam int DW = 8 * WORD_BYTES;

  if (WORD_BYTES != 1 && WORD_BYTES != 2 && WORD_BYTES != 4) begin : g_bad_word_bytes
    $error("sram_burst_ctrl: WORD_BYTES must be 1, 2 or 4");
  end
  if (ADDR_W - LB > RAM_AW) begin : g_bad_ram_aw
    $error("sram_burst_ctrl: RAM_AW too small for ADDR_W");
  end
  if (ADDR_W < 9 || ADDR_W > 16) begin : g_bad_addr_w
    $error("sram_burst_ctrl: ADDR_W must be 9..16");
  end

  logic              cmd_evt;
  logic [1:0]        cmd;
  logic              no_inc;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LW-1:0]     lane_cur;
  logic [LW-1:0]     lane_q;
  logic              no_inc_q;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              overrun;
  logic              ready_q;
  logic              csb_q;
  logic              web_q;
  logic [WORD_BYTES-1:0] wmask_q;
  logic [RAM_AW-1:0] addr_q;
  logic [DW-1:0]     din_q;
  logic [RAM_AW-1:0] word_cur;
  logic [WORD_BYTES-1:0] mask_cur;
  logic [DW-1:0]     din_cur;
  logic [7:0]        rd_byte;
  logic              unused_inputs;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[2]),
    .rise  (cmd_evt)
  );

  assign cmd    = uio_in[1:0];
  assign no_inc = uio_in[3];
  assign unused_inputs = &{1'b0, ena, uio_in[7:4]};

  if (LB == 0) begin : g_lane_none
    assign lane_cur = '0;
  end else begin : g_lane
    assign lane_cur = addr[LB-1:0];
  end

  assign word_cur = RAM_AW'(addr >> LB);
  assign mask_cur = WORD_BYTES'(1) << lane_cur;
  assign din_cur  = DW'(ui_in) << (8 * lane_cur);
  assign rd_byte  = ram.ram_dout0[8*lane_q +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      lane_q   <= '0;
      no_inc_q <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      ready_q  <= 1'b1;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      wmask_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      din_q   <= '0;
      if (cmd_evt && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cmd_evt) begin
            rd_valid <= 1'b0;
            no_inc_q <= no_inc;
            lane_q   <= lane_cur;
            case (cmd)
              CMD_LOAD_LO: begin
                addr[7:0] <= ui_in;
                overrun   <= 1'b0;
              end
              CMD_LOAD_HI: addr <= ADDR_W'({ui_in, addr[7:0]});
              CMD_WRITE: begin
                state   <= WR;
                ready_q <= 1'b0;
                csb_q   <= 1'b0;
                web_q   <= 1'b0;
                wmask_q <= mask_cur;
                din_q   <= din_cur;
                addr_q  <= word_cur;
              end
              default: begin
                state   <= RD_ISSUE;
                ready_q <= 1'b0;
                csb_q   <= 1'b0;
                addr_q  <= word_cur;
              end
            endcase
          end
        end
        WR: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          if (!no_inc_q) addr <= addr + ADDR_W'(1);
        end
        RD_ISSUE: begin
          state <= RD_CAP;
          if (!no_inc_q) addr <= addr + ADDR_W'(1);
        end
        RD_CAP: begin
          state    <= IDLE;
          ready_q  <= 1'b1;
          rd_data  <= rd_byte;
          rd_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the strobes combinationally so an access caught by reset never
  // reaches the RAM at the reset edge itself.
  assign ram.ram_csb0   = csb_q | ~rst_n;
  assign ram.ram_web0   = web_q | ~rst_n;
  assign ram.ram_wmask0 = rst_n ? wmask_q : '0;
  assign ram.ram_addr0  = addr_q;
  assign ram.ram_din0   = din_q;

  assign ram_clk0 = clk;
  assign uo_out   = rd_data;
  assign uio_out  = {ready_q, rd_valid, overrun, 5'b0};
  assign uio_oe   = 8'hE0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - scoreboard bench for sram_burst_ctrl with a behavioural SRAM model
module tb_sram_burst_ctrl;

  localparam logic [1:0] C_LO = 2'd0;
  localparam logic [1:0] C_HI = 2'd1;
  localparam logic [1:0] C_WR = 2'd2;
  localparam logic [1:0] C_RD = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ram_clk0;

  int n_checks = 0;
  int n_err = 0;

  sram_burst_ctrl_if #(.WORD_BYTES(4), .RAM_AW(9)) ram_bus ();

  sram_burst_ctrl #(.ADDR_W(11), .WORD_BYTES(4), .RAM_AW(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .ui_in    (ui_in),
    .uio_in   (uio_in),
    .uo_out   (uo_out),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .ram_clk0 (ram_clk0),
    .ram      (ram_bus)
  );

  always #5 clk = ~clk;

  wire ready    = uio_out[7];
  wire rd_valid = uio_out[6];
  wire overrun  = uio_out[5];

  // SRAM macro model: registered read, byte-masked write.
  logic [31:0] mem [0:511];
  always @(posedge ram_clk0) begin
    if (ram_bus.ram_csb0 === 1'b0) begin
      if (ram_bus.ram_web0 === 1'b0) begin
        logic [31:0] w;
        w = mem[ram_bus.ram_addr0];
        for (int b = 0; b < 4; b++)
          if (ram_bus.ram_wmask0[b]) w[8*b +: 8] = ram_bus.ram_din0[8*b +: 8];
        mem[ram_bus.ram_addr0] <= w;
      end else begin
        ram_bus.ram_dout0 <= mem[ram_bus.ram_addr0];
      end
    end
  end

  typedef struct packed {
    logic [8:0]  a;
    logic [3:0]  m;
    logic [31:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] ref_mem [0:2047];
  logic [10:0] m_addr = '0;

  logic [8:0]  last_wa = '0;
  logic [3:0]  last_wm = '0;
  logic [31:0] last_wd = '0;
  logic [7:0]  last_rd = '0;
  logic        rv_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ram_bus.ram_csb0 === 1'b0 && ram_bus.ram_web0 === 1'b0) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      last_wa = ram_bus.ram_addr0;
      last_wm = ram_bus.ram_wmask0;
      last_wd = ram_bus.ram_din0;
      if (wr_q.size() != 0) begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(ram_bus.ram_addr0), 32'(e.a));
        check("wr_mask", 32'(ram_bus.ram_wmask0), 32'(e.m));
        check("wr_din", ram_bus.ram_din0, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rd_valid && !rv_d) begin
      check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      last_rd = uo_out;
      if (rd_q.size() != 0) check("rd_data", 32'(uo_out), 32'(rd_q.pop_front()));
    end
    rv_d = rd_valid;
  end

  task automatic model_cmd(input logic [1:0] c, input logic [7:0] d, input logic ni);
    case (c)
      C_LO: m_addr[7:0] = d;
      C_HI: m_addr[10:8] = d[2:0];
      C_WR: begin
        wr_q.push_back('{a: m_addr[10:2], m: 4'b0001 << m_addr[1:0],
                         d: 32'(d) << (8 * m_addr[1:0])});
        ref_mem[m_addr] = d;
        if (!ni) m_addr = m_addr + 11'd1;
      end
      default: begin
        rd_q.push_back(ref_mem[m_addr]);
        if (!ni) m_addr = m_addr + 11'd1;
      end
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic ni);
    @(negedge clk);
    ui_in  = d;
    uio_in = {4'h0, ni, 1'b0, c};
    repeat (3) @(negedge clk);
    uio_in[2] = 1'b1;
    model_cmd(c, d, ni);
    @(posedge clk); @(posedge clk); #1;
    check("ready_at_e", 32'(ready), 32'd1);
    @(posedge clk); #1;
    check("ready_e1", 32'(ready), (c == C_WR || c == C_RD) ? 32'd0 : 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check("ready_e3", 32'(ready), 32'd1);
    if (c == C_RD) check("rd_valid_e3", 32'(rd_valid), 32'd1);
    @(negedge clk);
    uio_in[2] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_rd [4];
    logic [31:0] w_before;
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    ram_bus.ram_dout0 = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_csb", 32'(ram_bus.ram_csb0), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_uo_out", 32'(uo_out), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_uio_low", 32'(uio_out[4:0]), 32'd0);
    check("uio_oe", 32'(uio_oe), 32'hE0);

    // Four bytes into word 0, then read them back.
    do_cmd(C_LO, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) do_cmd(C_WR, exp_rd[i], 1'b0);
    do_cmd(C_LO, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cmd(C_RD, 8'h00, 1'b0);
      check("seq_rd", 32'(last_rd), 32'(exp_rd[i]));
    end

    // Lane 1 of word 0x41, then auto-increment to 0x106.
    do_cmd(C_LO, 8'h05, 1'b0);
    do_cmd(C_HI, 8'h01, 1'b0);
    do_cmd(C_WR, 8'hA5, 1'b0);
    check("lane_wa", 32'(last_wa), 32'h041);
    check("lane_wm", 32'(last_wm), 32'b0010);
    check("lane_wd", last_wd, 32'h0000A500);
    do_cmd(C_WR, 8'h5A, 1'b0);
    check("inc_wa", 32'(last_wa), 32'h041);
    check("inc_wm", 32'(last_wm), 32'b0100);

    // Top byte of the space, then wrap to 0.
    do_cmd(C_HI, 8'h07, 1'b0);
    do_cmd(C_LO, 8'hFF, 1'b0);
    do_cmd(C_WR, 8'hC3, 1'b0);
    check("top_wa", 32'(last_wa), 32'h1FF);
    check("top_wm", 32'(last_wm), 32'b1000);
    check("top_wd", last_wd, 32'hC3000000);
    do_cmd(C_WR, 8'h3C, 1'b0);
    check("wrap_wa", 32'(last_wa), 32'h000);
    check("wrap_wm", 32'(last_wm), 32'b0001);
    check("wrap_wd", last_wd, 32'h0000003C);

    // no_inc reads hold the address.
    do_cmd(C_HI, 8'h01, 1'b0);
    do_cmd(C_LO, 8'h05, 1'b0);
    do_cmd(C_RD, 8'h00, 1'b1);
    check("noinc_rd1", 32'(last_rd), 32'hA5);
    do_cmd(C_RD, 8'h00, 1'b1);
    check("noinc_rd2", 32'(last_rd), 32'hA5);
    do_cmd(C_RD, 8'h00, 1'b0);
    check("noinc_rd3", 32'(last_rd), 32'hA5);
    do_cmd(C_RD, 8'h00, 1'b0);
    check("noinc_rd4", 32'(last_rd), 32'h5A);

    // Second strobe edge while the read is in flight.
    @(negedge clk);
    uio_in = {4'h0, 1'b0, 1'b0, C_RD};
    repeat (3) @(negedge clk);
    uio_in[2] = 1'b1;
    model_cmd(C_RD, 8'h00, 1'b0);
    @(negedge clk); uio_in[2] = 1'b0;
    @(negedge clk); uio_in[2] = 1'b1;
    @(posedge clk); #1;
    check("ovr_before", 32'(overrun), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_rd_valid", 32'(rd_valid), 32'd1);
    check("ovr_ready", 32'(ready), 32'd1);
    @(negedge clk); uio_in[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("ovr_rd", 32'(last_rd), 32'h00);
    do_cmd(C_HI, 8'h00, 1'b0);
    check("ovr_kept_hi", 32'(overrun), 32'd1);
    do_cmd(C_LO, 8'h10, 1'b0);
    check("ovr_clr_lo", 32'(overrun), 32'd0);

    // Reset asserted during the WR cycle aborts the write to word 4.
    w_before = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
    @(negedge clk);
    ui_in  = 8'hEE;
    uio_in = {4'h0, 1'b0, 1'b0, C_WR};
    repeat (3) @(negedge clk);
    uio_in[2] = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check("abort_wr_active", 32'(ram_bus.ram_csb0), 32'd0);
    rst_n = 1'b0;
    uio_in[2] = 1'b0;
    #1;
    check("abort_csb_gated", 32'(ram_bus.ram_csb0), 32'd1);
    @(posedge clk); #1;
    check("abort_csb", 32'(ram_bus.ram_csb0), 32'd1);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_uo_out", 32'(uo_out), 32'd0);
    check("abort_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0;
    @(negedge clk);
    check("abort_mem", mem[4], w_before);

    do_cmd(C_RD, 8'h00, 1'b0);
    check("post_rst_rd", 32'(last_rd), 32'h3C);

    repeat (4) @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 11, as the byte-address width.
REQ-002 The block SHALL take parameter WORD_BYTES, default 4, as the RAM word width in bytes; legal values are 1, 2 and 4; LB = log2(WORD_BYTES).
REQ-003 The block SHALL take parameter RAM_AW, default 9, as the RAM word-address width; elaboration SHALL fail if ADDR_W-LB > RAM_AW.
REQ-004 clk  in  1  clock; reset rst_n, synchronous, active-low.
REQ-005 ena  in  1  tile enable; ignored.
REQ-006 ui_in  in  8  write data byte.
REQ-007 uio_in  in  8  [1:0] cmd, [2] strobe (asynchronous), [3] no_inc; [7:4] ignored.
REQ-008 uo_out  out  8  read data register.
REQ-009 uio_out  out  8  [7] ready, [6] rd_valid, [5] overrun; [4:0] = 0.
REQ-010 uio_oe  out  8  constant 8'hE0.
REQ-011 ram_clk0 = clk; ram_csb0 out 1 (active low); ram_web0 out 1 (active low).
REQ-012 ram_wmask0  out  WORD_BYTES  byte write mask.
REQ-013 ram_addr0  out  RAM_AW  word address; ram_din0 out 8*WORD_BYTES; ram_dout0 in 8*WORD_BYTES.

Function
REQ-014 strobe SHALL pass through a 2-flop synchronizer; a command event E is the cycle in which the synced strobe is 1 and its previous value was 0.
REQ-015 At E, cmd, no_inc and ui_in SHALL be latched; the host holds them stable from 3 cycles before the strobe edge until ready returns.
REQ-016 Commands: 0 LOAD_LO sets addr[7:0] = latched data; 1 LOAD_HI sets addr[ADDR_W-1:8] = latched data (truncated); 2 WRITE; 3 READ.
REQ-017 LOAD_LO and LOAD_HI SHALL complete at E with no RAM access and no drop of ready.
REQ-018 LOAD_LO SHALL also clear overrun.
REQ-019 FSM states: IDLE, WR, RD_ISSUE, RD_CAP.
REQ-020 FSM transitions: IDLE -> WR on WRITE; IDLE -> RD_ISSUE on READ; WR -> IDLE; RD_ISSUE -> RD_CAP; RD_CAP -> IDLE.
REQ-021 ready SHALL be 1 only in IDLE.
REQ-022 WR (cycle E+1): csb=0, web=0, ram_addr0 = addr[ADDR_W-1:LB] zero-extended.
REQ-023 WR: wmask one-hot at lane addr[LB-1:0]; din = data shifted left by 8*lane, other bits 0.
REQ-024 RD_ISSUE (E+1): csb=0, web=1, wmask=0, same address mapping as WR.
REQ-025 RD_CAP (E+2): rd_data <= ram_dout0 byte at the lane; csb=1.
REQ-026 uo_out SHALL show rd_data from E+3; rd_valid SHALL be 1 from E+3.
REQ-027 rd_valid SHALL clear on the next command event.
REQ-028 Outside WR and RD_ISSUE: csb=1, web=1, wmask=0, din=0.
REQ-029 At the end of WR or RD_ISSUE, addr SHALL increment by 1 modulo 2^ADDR_W unless no_inc was latched; increment carries across word boundaries.
REQ-030 A command event while not IDLE SHALL be ignored and SHALL set sticky overrun.
REQ-031 A strobe held high SHALL yield exactly one event.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, addr=0, rd_data=0, rd_valid=0, overrun=0, synchronizer flops=0.
REQ-033 In the cycle after that edge, csb=1, ready=1 and uo_out=0.
REQ-034 Reset asserted in WR or RD_ISSUE SHALL abort the access; csb=1 from the first reset edge, and no partial write completes after it.

Structure
REQ-035 Package sram_burst_pkg SHALL hold the cmd encodings (CMD_LOAD_LO=0, CMD_LOAD_HI=1, CMD_WRITE=2, CMD_READ=3) and the state enum.
REQ-036 Sub-module sync_edge SHALL hold the 2-flop synchronizer and rising-edge detect; all other logic stays in sram_burst_ctrl.

Verification
REQ-037 The bench SHALL cover: LOAD_LO 0x05, LOAD_HI 0x01, WRITE 0xA5 -> at E+1 ram_addr0=0x41, wmask=4'b0010, din=0x0000A500; addr becomes 0x106.
REQ-038 The bench SHALL cover: WRITE 0x11, 0x22, 0x33, 0x44 from addr 0, then LOAD_LO 0 and 4 READs -> uo_out 0x11, 0x22, 0x33, 0x44, each at E+3 with rd_valid=1.
REQ-039 The bench SHALL cover: LOAD_HI 0x07, LOAD_LO 0xFF, WRITE -> written at word 0x1FF lane 3; addr wraps to 0x000.
REQ-040 The bench SHALL cover: READ with no_inc=1 issued twice -> same byte twice; addr unchanged.
REQ-041 The bench SHALL cover: a second strobe edge arriving 1 cycle after a READ event -> ignored, overrun=1; a later LOAD_LO clears overrun.
REQ-042 The bench SHALL cover: rst_n low in the WR cycle -> csb=1 from that edge, ready=1 and uo_out=0 next cycle, and RAM contents unchanged.
